bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
Multi-digit BCD up/down counter with a built-in digit scanner. It drives the existing BCD-to-seven-segment decoder with one BCD digit at a time (bcd[3:0]) and gives a matching one-hot digit select. It sits directly upstream of the decoder. Together they form a time-multiplexed multi-digit display path.

Parameters:
NUM_DIGITS, 4, number of BCD digits counted and scanned (1..8)
TICK_DIV, 50000000, clk cycles per count step while en=1 (>=1)
SCAN_DIV, 50000, clk cycles per scanned digit (>=1)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; gates the step prescaler only
up  input  1  1 = count up, 0 = count down; sampled on the step cycle
clear  input  1  synchronous clear of count to all zeros
load  input  1  synchronous parallel load of load_val
load_val  input  4*NUM_DIGITS  packed BCD load value, digit 0 in [3:0]
count  output  4*NUM_DIGITS  full registered BCD count, digit 0 = least significant
bcd  output  4  currently scanned digit, feeds decoder bcd input
digit_sel  output  NUM_DIGITS  one-hot active-high select, bit i = digit i
wrap  output  1  one-cycle pulse on rollover

Behaviour:
- One clock domain. Reset is synchronous and active-high; it applies only on a clk edge with rst=1.
- Reset values:
  - count=0, bcd=0, digit_sel=1 (digit 0), wrap=0.
  - Step prescaler=0, scan prescaler=0, scan index=0.
- Priority each cycle: rst > clear > load > step.
- Step prescaler:
  - Counts 0..TICK_DIV-1 only while en=1.
  - Holds its value while en=0.
  - step=1 for exactly the cycle it is at TICK_DIV-1 with en=1; it then returns to 0.
  - clear or load resets the prescaler to 0.
- Step up: digit 0 increments. A digit going 9->0 carries into the next digit. All-9s -> all-0s asserts wrap.
- Step down: digit 0 decrements. A digit going 0->9 borrows from the next digit. All-0s -> all-9s asserts wrap.
- wrap is registered. It is high on the same cycle the wrapped count first appears on count.
- clear: count <= 0, wrap=0.
- load:
  - count <= load_val, digit by digit.
  - Any load_val digit >9 is clamped to 9; other digits load unchanged.
  - wrap=0.
- The count stays legal BCD (every digit 0..9) at all times.
- Scanner (independent of en, clear and load; reset only by rst):
  - The scan prescaler counts 0..SCAN_DIV-1 continuously.
  - At terminal count the index advances: index NUM_DIGITS-1 wraps to 0.
- bcd and digit_sel are registered: bcd = count digit[index] and digit_sel = 1<<index, both as of the previous cycle. This gives a 1-cycle latency from an index or count change.
- digit_sel always has exactly one bit set, including directly after reset.
- rst mid-count or mid-scan returns every register to its reset value on the next edge. No partial state survives.
- A step on the same cycle as clear or load is dropped; the prescaler restarts.
- NUM_DIGITS=1 is legal: the index is stuck at 0 and digit_sel=1.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W=4, BCD_MAX=4'd9.
  - Functions bcd_inc(digit, cin) -> {cout, digit} and bcd_dec(digit, bin) -> {bout, digit}.
  - bcd_clamp(digit).
- One natural sub-module: bcd_digit_cell.
  - One digit register with inc/dec, carry/borrow in/out, clear and load.
  - Instantiated NUM_DIGITS times in a generate chain.
- The prescalers and scanner stay in the top level.

Test Plan:
- TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=4; rst 2 cycles, then en=1, up=1 -> count steps every 4 clks: 0000, 0001 ... 0009, 0010. digit_sel cycles 0001, 0010, 0100, 1000 every 2 clks. bcd matches the selected digit one cycle later.
- load load_val=16'h9999, then en=1, up=1 -> after 4 clks count=0000 and wrap high for exactly 1 cycle. Repeat with load 0000, up=0 -> count=9999 and wrap pulse.
- load load_val=16'h1A3F -> count=16'h1939 (clamped digits). The next step up gives 1940.
- en toggled 1,0,0,1 mid-prescale -> prescaler holds while en=0, so a step occurs only after 4 enabled cycles in total. clear asserted together with a step -> count=0000 and no increment.
- rst asserted mid-scan at index 2 with count=0573 -> next edge: count=0, digit_sel=0001, bcd=0, wrap=0.
- Feed bcd into the sevensegment decoder for counts 0..9 on digit 0 -> the decoder output matches the expected segment pattern for each value while digit_sel=0001.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit width, limits and single-digit arithmetic helpers.
// Used by the digit cell and the scanning counter top.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Returns {carry_out, next_digit}; a digit at 9 rolls to 0 with carry.
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic cin);
    if (!cin)              return {1'b0, digit};
    if (digit >= BCD_MAX)  return {1'b1, 4'd0};
    return {1'b0, digit + 4'd1};
  endfunction

  // Returns {borrow_out, next_digit}; a digit at 0 rolls to 9 with borrow.
  function automatic logic [4:0] bcd_dec(input logic [3:0] digit, input logic bin);
    if (!bin)          return {1'b0, digit};
    if (digit == 4'd0) return {1'b1, BCD_MAX};
    return {1'b0, digit - 4'd1};
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with up/down step, carry/borrow chaining, clear and clamped load.
// Latency 1 cycle; cout is combinational so a whole chain ripples within one cycle.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_dig,
  input  logic             up,
  input  logic             cin,
  output logic [BCD_W-1:0] dig,
  output logic             cout
);

  logic [4:0] nxt;

  always_comb begin
    nxt  = up ? bcd_inc(dig, cin) : bcd_dec(dig, cin);
    cout = nxt[4];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      dig <= '0;
    end else if (load) begin
      dig <= bcd_clamp(load_dig);
    end else begin
      dig <= nxt[3:0];
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with step prescaler and a time-multiplexed digit scanner.
// bcd/digit_sel lag the scan index and count by one registered cycle.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up,
  input  logic                        clear,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic [BCD_W-1:0]            bcd,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        wrap
);

  localparam int TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TW-1:0]       tick_pre;
  logic                tick_tc;
  logic                step;
  logic [NUM_DIGITS:0] chain;
  logic [SW-1:0]       scan_pre;
  logic                scan_tc;
  logic [IW-1:0]       idx;

  // A terminal count coinciding with clear/load is swallowed, not deferred.
  assign tick_tc  = en && (tick_pre == TW'(TICK_DIV - 1));
  assign step     = tick_tc && !clear && !load;
  assign chain[0] = step;

  always_ff @(posedge clk) begin
    if (rst || clear || load) begin
      tick_pre <= '0;
    end else if (en) begin
      tick_pre <= tick_tc ? '0 : tick_pre + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .load     (load),
        .load_dig (load_val[gi*BCD_W +: BCD_W]),
        .up       (up),
        .cin      (chain[gi]),
        .dig      (count[gi*BCD_W +: BCD_W]),
        .cout     (chain[gi+1])
      );
    end
  endgenerate

  // Carry/borrow out of the top digit only exists on a step, so it marks rollover.
  always_ff @(posedge clk) begin
    if (rst || clear || load) begin
      wrap <= 1'b0;
    end else begin
      wrap <= chain[NUM_DIGITS];
    end
  end

  assign scan_tc = (scan_pre == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_pre  <= '0;
      idx       <= '0;
      bcd       <= '0;
      digit_sel <= NUM_DIGITS'(1);
    end else begin
      scan_pre  <= scan_tc ? '0 : scan_pre + 1'b1;
      if (scan_tc) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      bcd       <= count[int'(idx)*BCD_W +: BCD_W];
      digit_sel <= NUM_DIGITS'(1) << idx;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized and directed bench for bcd_scan_counter against a decimal-arithmetic model.
module tb_bcd_scan_counter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam int MODV = 10000;

  logic          clk = 1'b0;
  logic          rst, en, up, clear, load;
  logic [4*N-1:0] load_val;
  logic [4*N-1:0] count;
  logic [3:0]     bcd;
  logic [N-1:0]   digit_sel;
  logic           wrap;

  bcd_scan_counter #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count), .bcd(bcd), .digit_sel(digit_sel), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit armed  = 0;

  // Model state: count as a plain decimal integer.
  int m_val = 0, m_tpre = 0, m_spre = 0, m_idx = 0;
  int m_bcd = 0, m_sel = 1;
  bit m_wrap = 0;

  function automatic int digit_of(int v, int i);
    return (v / (10 ** i)) % 10;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(int v);
    logic [4*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic int from_load(logic [4*N-1:0] lv);
    int v = 0;
    for (int i = 0; i < N; i++) begin
      int d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * (10 ** i);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_val = 0; m_tpre = 0; m_spre = 0; m_idx = 0;
      m_bcd = 0; m_sel = 1; m_wrap = 0;
    end else begin
      m_bcd = digit_of(m_val, m_idx);
      m_sel = 1 << m_idx;
      if (m_spre == SD - 1) begin
        m_spre = 0;
        m_idx  = (m_idx + 1) % N;
      end else begin
        m_spre++;
      end
      m_wrap = 0;
      if (clear) begin
        m_val = 0; m_tpre = 0;
      end else if (load) begin
        m_val = from_load(load_val); m_tpre = 0;
      end else if (en) begin
        if (m_tpre == TD - 1) begin
          m_tpre = 0;
          if (up) begin
            m_wrap = (m_val == MODV - 1);
            m_val  = (m_val + 1) % MODV;
          end else begin
            m_wrap = (m_val == 0);
            m_val  = (m_val + MODV - 1) % MODV;
          end
        end else begin
          m_tpre++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("count",     32'(count),     32'(to_bcd(m_val)));
      chk("bcd",       32'(bcd),       32'(m_bcd));
      chk("digit_sel", 32'(digit_sel), 32'(m_sel));
      chk("wrap",      32'(wrap),      32'(m_wrap));
      chk("onehot",    32'($onehot(digit_sel)), 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*N-1:0] v);
    en = 0; load = 1; load_val = v;
    cyc(1);
    load = 0;
  endtask

  initial begin
    int waited;
    rst = 1; en = 0; up = 1; clear = 0; load = 0; load_val = '0;
    cyc(2);
    armed = 1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_sel",   32'(digit_sel), 32'h1);
    chk("rst_bcd",   32'(bcd), 32'h0);
    chk("rst_wrap",  32'(wrap), 32'h0);
    rst = 0;

    // Ten steps at four clocks each.
    en = 1; up = 1;
    cyc(40);
    chk("ten_steps", 32'(count), 32'h0010);

    do_load(16'h9999);
    en = 1; up = 1;
    cyc(4);
    chk("up_wrap_count", 32'(count), 32'h0000);
    chk("up_wrap_pulse", 32'(wrap), 32'h1);
    cyc(1);
    chk("up_wrap_gone", 32'(wrap), 32'h0);

    do_load(16'h0000);
    en = 1; up = 0;
    cyc(4);
    chk("dn_wrap_count", 32'(count), 32'h9999);
    chk("dn_wrap_pulse", 32'(wrap), 32'h1);

    do_load(16'h1A3F);
    chk("clamp_load", 32'(count), 32'h1939);
    en = 1; up = 1;
    cyc(4);
    chk("clamp_step", 32'(count), 32'h1940);

    // Prescaler holds while disabled.
    do_load(16'h0000);
    up = 1;
    en = 1; cyc(2);
    en = 0; cyc(2);
    en = 1; cyc(1);
    chk("en_hold", 32'(count), 32'h0000);
    cyc(1);
    chk("en_step", 32'(count), 32'h0001);

    // Clear on the step cycle drops the step and restarts the prescaler.
    cyc(3);
    clear = 1; cyc(1);
    clear = 0;
    chk("clr_step", 32'(count), 32'h0000);
    cyc(3);
    chk("clr_restart", 32'(count), 32'h0000);
    cyc(1);
    chk("clr_next", 32'(count), 32'h0001);

    // Reset mid-scan at index 2.
    do_load(16'h0573);
    waited = 0;
    while (m_idx != 2 && waited < 20) begin cyc(1); waited++; end
    chk("scan_idx2_reached", 32'(m_idx), 32'd2);
    rst = 1; cyc(1); rst = 0;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_sel",   32'(digit_sel), 32'h1);
    chk("mid_rst_bcd",   32'(bcd), 32'h0);
    chk("mid_rst_wrap",  32'(wrap), 32'h0);

    // Decoder feed: each value on digit 0 appears on bcd while digit 0 is selected.
    for (int v = 0; v < 10; v++) begin
      do_load(16'(v));
      cyc(2);
      waited = 0;
      while (digit_sel != 4'b0001 && waited < 12) begin cyc(1); waited++; end
      chk("dec_sel", 32'(digit_sel), 32'h1);
      chk("dec_bcd", 32'(bcd), 32'(v));
    end

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 7) != 0) ? up : ~up;
      clear    = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 3);
      load_val = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_val = 16'(($urandom_range(0, 1)) ? 16'h9999 : 16'h0000);
      cyc(1);
    end
    rst = 0; en = 0; clear = 0; load = 0;
    cyc(1);
    armed = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
